flap_game_ctrl: RTL and testbench

//  Game-flow sequencer for the flappy-bird datapath. Owns gameOn/ded and the bird restart pulse.

---
 rtl/flap_game_if.sv | 37 +++
 rtl/flap_game_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_flap_game_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/flap_game_if.sv
// Signal bundle between the flappy-bird game sequencer and its surroundings.
// master: keyboard/bird/pipe side (drives inputs). slave: the sequencer.
// Optional feature macro: FLAP_HISCORE_EN adds hiscore_bcd.
interface flap_game_if;
   logic        space;
   logic [9:0]  bird_y;
   logic [9:0]  bird_s;
   logic        collide;
   logic        pipe_pass;
   logic        gameOn;
   logic        ded;
   logic        bird_rst;
   logic [11:0] score_bcd;
   logic [1:0]  game_state;
   logic        flash;
`ifdef FLAP_HISCORE_EN
   logic [11:0] hiscore_bcd;

   modport master (
      output space, bird_y, bird_s, collide, pipe_pass,
      input  gameOn, ded, bird_rst, score_bcd, game_state, flash, hiscore_bcd
   );
   modport slave (
      input  space, bird_y, bird_s, collide, pipe_pass,
      output gameOn, ded, bird_rst, score_bcd, game_state, flash, hiscore_bcd
   );
`else
   modport master (
      output space, bird_y, bird_s, collide, pipe_pass,
      input  gameOn, ded, bird_rst, score_bcd, game_state, flash
   );
   modport slave (
      input  space, bird_y, bird_s, collide, pipe_pass,
      output gameOn, ded, bird_rst, score_bcd, game_state, flash
   );
`endif
endinterface

// File: rtl/flap_game_ctrl.sv
// Game-flow sequencer: IDLE -> START -> PLAY -> DYING -> OVER -> START ...
// Owns gameOn/ded, the one-frame bird restart pulse, the BCD score and the
// death-overlay flash. Everything advances once per frame_clk.
// All outputs are registered from the next state, so a change is visible
// on the same edge that enters the state.
// Optional feature macro: FLAP_HISCORE_EN (adds hiscore_bcd, updated on DYING->OVER).
module flap_game_ctrl #(
   parameter int FLOOR_Y      = 478,
   parameter int DYING_FRAMES = 60,
   parameter int FLASH_DIV    = 8
) (
   input  logic       frame_clk,
   input  logic       Reset,
   flap_game_if.slave bus
);

   localparam int DW = (DYING_FRAMES > 1) ? $clog2(DYING_FRAMES) : 1;
   localparam int FW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_PLAY  = 3'd2,
      S_DYING = 3'd3,
      S_OVER  = 3'd4
   } state_t;

   state_t      state_reg, state_next;
   logic        space_q_reg;
   logic [DW-1:0] dcnt_reg, dcnt_next;
   logic [FW-1:0] fcnt_reg, fcnt_next;
   logic        flash_reg, flash_next;
   logic        game_on_reg, game_on_next;
   logic        ded_reg, ded_next;
   logic        bird_rst_reg, bird_rst_next;
   logic [1:0]  game_state_reg, game_state_next;
   logic [11:0] score_reg, score_next;

   logic        press;
   logic [10:0] floor_sum;
   logic        floor_hit;
   logic        death;
   logic [11:0] score_inc;
   logic [2:0]  carry;

   // Rising edge of the flap key; a key held across states never counts twice.
   assign press     = bus.space & ~space_q_reg;
   // 11-bit sum so a large bird_y+bird_s cannot wrap below the floor.
   assign floor_sum = {1'b0, bus.bird_y} + {1'b0, bus.bird_s};
   // bit9 set means the bird is above the top of the screen, never on the floor.
   assign floor_hit = ~bus.bird_y[9] & (floor_sum >= 11'(FLOOR_Y));
   assign death     = bus.collide | floor_hit;

   // BCD +1 with ripple carry through the three digits.
   assign carry[0] = 1'b1;
   for (genvar gi = 0; gi < 3; gi++) begin : g_bcd_inc
      logic [3:0] digit;
      logic       wrap;
      assign digit = score_reg[4*gi +: 4];
      assign wrap  = carry[gi] & (digit == 4'd9);
      assign score_inc[4*gi +: 4] = wrap ? 4'd0 : (digit + {3'b000, carry[gi]});
      if (gi < 2) begin : g_carry
         assign carry[gi+1] = wrap;
      end
   end

   // Next-state, counters and registered-output values.
   always_comb begin
      state_next      = state_reg;
      dcnt_next       = dcnt_reg;
      fcnt_next       = '0;
      flash_next      = 1'b0;
      score_next      = score_reg;
      game_on_next    = 1'b0;
      ded_next        = 1'b0;
      bird_rst_next   = 1'b0;
      game_state_next = 2'd0;

      case (state_reg)
         S_IDLE: begin
            if (press) state_next = S_START;
         end
         S_START: begin
            state_next = S_PLAY;
         end
         S_PLAY: begin
            if (death) begin
               state_next = S_DYING;
               dcnt_next  = '0;
            end else if (bus.pipe_pass && (score_reg != 12'h999)) begin
               score_next = score_inc;
            end
         end
         S_DYING: begin
            dcnt_next = dcnt_reg + DW'(1);
            if (dcnt_reg == DW'(DYING_FRAMES - 1)) state_next = S_OVER;
         end
         S_OVER: begin
            if (press) state_next = S_START;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase

      // Entering START wipes the score for the new round.
      if (state_next == S_START) score_next = '0;

      // Flash only runs while staying in DYING; anywhere else it is held low.
      if ((state_reg == S_DYING) && (state_next == S_DYING)) begin
         if (fcnt_reg == FW'(FLASH_DIV - 1)) begin
            flash_next = ~flash_reg;
            fcnt_next  = '0;
         end else begin
            flash_next = flash_reg;
            fcnt_next  = fcnt_reg + FW'(1);
         end
      end

      case (state_next)
         S_START: begin
            bird_rst_next   = 1'b1;
            game_state_next = 2'd1;
         end
         S_PLAY: begin
            game_on_next    = 1'b1;
            game_state_next = 2'd1;
         end
         S_DYING: begin
            game_on_next    = 1'b1;
            ded_next        = 1'b1;
            game_state_next = 2'd2;
         end
         S_OVER: begin
            ded_next        = 1'b1;
            game_state_next = 2'd3;
         end
         default: begin
            game_state_next = 2'd0;
         end
      endcase
   end

   // State, counters and output registers.
   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         state_reg      <= S_IDLE;
         space_q_reg    <= 1'b0;
         dcnt_reg       <= '0;
         fcnt_reg       <= '0;
         flash_reg      <= 1'b0;
         score_reg      <= '0;
         game_on_reg    <= 1'b0;
         ded_reg        <= 1'b0;
         bird_rst_reg   <= 1'b0;
         game_state_reg <= 2'd0;
      end else begin
         state_reg      <= state_next;
         space_q_reg    <= bus.space;
         dcnt_reg       <= dcnt_next;
         fcnt_reg       <= fcnt_next;
         flash_reg      <= flash_next;
         score_reg      <= score_next;
         game_on_reg    <= game_on_next;
         ded_reg        <= ded_next;
         bird_rst_reg   <= bird_rst_next;
         game_state_reg <= game_state_next;
      end
   end

   assign bus.gameOn     = game_on_reg;
   assign bus.ded        = ded_reg;
   assign bus.bird_rst   = bird_rst_reg;
   assign bus.score_bcd  = score_reg;
   assign bus.game_state = game_state_reg;
   assign bus.flash      = flash_reg;

`ifdef FLAP_HISCORE_EN
   logic [11:0] hiscore_reg;
   logic [2:0]  dig_gt;
   logic        hund_eq, tens_eq;
   logic        score_gt;

   for (genvar gi = 0; gi < 3; gi++) begin : g_hi_cmp
      assign dig_gt[gi] = score_reg[4*gi +: 4] > hiscore_reg[4*gi +: 4];
   end
   assign hund_eq  = score_reg[11:8] == hiscore_reg[11:8];
   assign tens_eq  = score_reg[7:4]  == hiscore_reg[7:4];
   // Digit-wise magnitude compare, most significant digit decides first.
   assign score_gt = dig_gt[2] | (hund_eq & dig_gt[1]) | (hund_eq & tens_eq & dig_gt[0]);

   // Latch a new best score when the death animation finishes.
   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         hiscore_reg <= '0;
      end else if ((state_reg == S_DYING) && (state_next == S_OVER) && score_gt) begin
         hiscore_reg <= score_reg;
      end
   end

   assign bus.hiscore_bcd = hiscore_reg;
`endif

endmodule

// File: tb/tb_flap_game_ctrl.sv
// Self-checking bench for flap_game_ctrl: a vector table, hand-written
// corner sequences, then randomized frames against a behavioural model.
module tb_flap_game_ctrl;
   localparam int FLOOR_Y      = 478;
   localparam int DYING_FRAMES = 60;
   localparam int FLASH_DIV    = 8;

   logic frame_clk = 1'b0;
   logic Reset     = 1'b1;
   int   checks    = 0;
   int   errors    = 0;

   flap_game_if bus();

   flap_game_ctrl #(
      .FLOOR_Y(FLOOR_Y), .DYING_FRAMES(DYING_FRAMES), .FLASH_DIV(FLASH_DIV)
   ) dut (
      .frame_clk(frame_clk),
      .Reset(Reset),
      .bus(bus.slave)
   );

   always #5 frame_clk = ~frame_clk;

   // ---------------- behavioural model ----------------
   // phase: 0 idle, 1 start, 2 play, 3 dying, 4 over
   int m_phase, m_score, m_k, m_hi;
   bit m_sp;

   function automatic logic [11:0] to_bcd(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic model_reset();
      m_phase = 0; m_score = 0; m_k = 0; m_hi = 0; m_sp = 0;
   endtask

   task automatic model_step();
      bit press, floor, dead;
      if (Reset) begin
         model_reset();
         return;
      end
      press = bus.space && !m_sp;
      m_sp  = bus.space;
      floor = (int'(bus.bird_y) < 512) && (int'(bus.bird_y) + int'(bus.bird_s) >= FLOOR_Y);
      dead  = bus.collide || floor;
      case (m_phase)
         0: if (press) begin m_phase = 1; m_score = 0; end
         1: m_phase = 2;
         2: if (dead) begin m_phase = 3; m_k = 0; end
            else if (bus.pipe_pass && m_score < 999) m_score++;
         3: begin
            m_k++;
            if (m_k == DYING_FRAMES) begin
               m_phase = 4;
               if (m_score > m_hi) m_hi = m_score;
            end
         end
         default: if (press) begin m_phase = 1; m_score = 0; end
      endcase
   endtask

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge frame_clk);
      model_step();
      #1;
   endtask

   task automatic idle_inputs();
      bus.space = 0; bus.bird_y = 10'd100; bus.bird_s = 10'd16;
      bus.collide = 0; bus.pipe_pass = 0;
   endtask

   task automatic apply_reset();
      idle_inputs();
      Reset = 1;
      repeat (5) tick();
      chk("rst state", 12'(bus.game_state), 12'd0);
      chk("rst gameOn", 12'(bus.gameOn), 12'd0);
      chk("rst ded", 12'(bus.ded), 12'd0);
      chk("rst score", bus.score_bcd, 12'h000);
      chk("rst bird_rst", 12'(bus.bird_rst), 12'd0);
      chk("rst flash", 12'(bus.flash), 12'd0);
      Reset = 0;
      model_reset();
   endtask

   task automatic start_game();
      bus.space = 0; tick();
      bus.space = 1; tick();
      chk("start bird_rst", 12'(bus.bird_rst), 12'd1);
      chk("start state", 12'(bus.game_state), 12'd1);
      tick();
      chk("play bird_rst", 12'(bus.bird_rst), 12'd0);
      chk("play gameOn", 12'(bus.gameOn), 12'd1);
      tick();
      chk("held no repulse", 12'(bus.bird_rst), 12'd0);
      bus.space = 0;
   endtask

   task automatic passes(input int n);
      bus.pipe_pass = 1;
      repeat (n) tick();
      bus.pipe_pass = 0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic       space;
      logic [9:0] bird_y;
      logic       collide;
      logic       pipe_pass;
      logic [1:0] e_state;
      logic       e_on;
      logic       e_ded;
      logic       e_rst;
      logic [11:0] e_score;
   } vec_t;

   vec_t vecs[10];

   initial begin
      vecs[0] = '{1'b0, 10'd100,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 12'h000};
      vecs[1] = '{1'b1, 10'd100,  1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 12'h000};
      vecs[2] = '{1'b1, 10'd100,  1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 12'h000};
      vecs[3] = '{1'b1, 10'd100,  1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 12'h001};
      vecs[4] = '{1'b0, 10'd100,  1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 12'h002};
      vecs[5] = '{1'b1, 10'd461,  1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 12'h002};
      vecs[6] = '{1'b1, 10'h3F0,  1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 12'h003};
      vecs[7] = '{1'b1, 10'd100,  1'b1, 1'b1, 2'd2, 1'b1, 1'b1, 1'b0, 12'h003};
      vecs[8] = '{1'b0, 10'd100,  1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 1'b0, 12'h003};
      vecs[9] = '{1'b1, 10'd100,  1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 12'h003};

      model_reset();
      apply_reset();

      for (int i = 0; i < 10; i++) begin
         bus.space = vecs[i].space; bus.bird_y = vecs[i].bird_y; bus.bird_s = 10'd16;
         bus.collide = vecs[i].collide; bus.pipe_pass = vecs[i].pipe_pass;
         tick();
         chk($sformatf("vec%0d state", i), 12'(bus.game_state), 12'(vecs[i].e_state));
         chk($sformatf("vec%0d gameOn", i), 12'(bus.gameOn), 12'(vecs[i].e_on));
         chk($sformatf("vec%0d ded", i), 12'(bus.ded), 12'(vecs[i].e_ded));
         chk($sformatf("vec%0d bird_rst", i), 12'(bus.bird_rst), 12'(vecs[i].e_rst));
         chk($sformatf("vec%0d score", i), bus.score_bcd, vecs[i].e_score);
         $display("vec %0d: state=%0d on=%0b ded=%0b rst=%0b score=%h",
                  i, bus.game_state, bus.gameOn, bus.ded, bus.bird_rst, bus.score_bcd);
      end

      // Score counting, digit carries and saturation.
      apply_reset();
      start_game();
      passes(12);  chk("score 012", bus.score_bcd, 12'h012);
      passes(87);  chk("score 099", bus.score_bcd, 12'h099);
      passes(1);   chk("score 100", bus.score_bcd, 12'h100);
      passes(899); chk("score 999", bus.score_bcd, 12'h999);
      passes(1);   chk("score sat", bus.score_bcd, 12'h999);
      $display("seq score: score=%h", bus.score_bcd);

      // Floor boundary.
      bus.bird_y = 10'd461; tick(); chk("y461 state", 12'(bus.game_state), 12'd1);
      bus.bird_y = 10'h3F0; tick(); chk("y3F0 state", 12'(bus.game_state), 12'd1);
      bus.bird_y = 10'd462; tick();
      chk("y462 state", 12'(bus.game_state), 12'd2);
      chk("y462 ded", 12'(bus.ded), 12'd1);
      $display("seq floor: state=%0d ded=%0b", bus.game_state, bus.ded);

      // Asynchronous reset mid-game, no clock edge needed.
      #2 Reset = 1; #1;
      chk("async rst state", 12'(bus.game_state), 12'd0);
      chk("async rst score", bus.score_bcd, 12'h000);
      chk("async rst bird_rst", 12'(bus.bird_rst), 12'd0);
      $display("seq async reset: state=%0d score=%h", bus.game_state, bus.score_bcd);

      // Death with simultaneous pass, dying duration, OVER restart rules.
      apply_reset();
      start_game();
      passes(5);
      bus.collide = 1; bus.pipe_pass = 1; bus.space = 1; tick();
      chk("collide state", 12'(bus.game_state), 12'd2);
      chk("collide score", bus.score_bcd, 12'h005);
      bus.collide = 0; bus.pipe_pass = 1;
      repeat (7) tick();
      chk("dying score", bus.score_bcd, 12'h005);
      tick();
      chk("flash on", 12'(bus.flash), 12'd1);
      bus.pipe_pass = 0;
      repeat (51) tick();
      chk("dying k59", 12'(bus.game_state), 12'd2);
      tick();
      chk("over state", 12'(bus.game_state), 12'd3);
      chk("over gameOn", 12'(bus.gameOn), 12'd0);
      chk("over flash", 12'(bus.flash), 12'd0);
      repeat (3) tick();
      chk("over held", 12'(bus.game_state), 12'd3);
      bus.space = 0; tick();
      bus.space = 1; tick();
      chk("restart rst", 12'(bus.bird_rst), 12'd1);
      chk("restart score", bus.score_bcd, 12'h000);
`ifdef FLAP_HISCORE_EN
      chk("hiscore kept", bus.hiscore_bcd, 12'h005);
`endif
      $display("seq death: state=%0d score=%h", bus.game_state, bus.score_bcd);

      // Randomized frames against the model.
      apply_reset();
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 5) == 0) bus.space = ~bus.space;
         if ($urandom_range(0, 99) < 3)      bus.bird_y = 10'($urandom_range(455, 470));
         else if ($urandom_range(0, 7) == 0) bus.bird_y = 10'($urandom_range(512, 1023));
         else                                bus.bird_y = 10'($urandom_range(0, 440));
         bus.bird_s    = 10'd16;
         bus.collide   = ($urandom_range(0, 199) == 0);
         bus.pipe_pass = ($urandom_range(0, 3) == 0);
         tick();
         chk("rnd state", 12'(bus.game_state),
             12'((m_phase == 0) ? 0 : (m_phase <= 2) ? 1 : (m_phase == 3) ? 2 : 3));
         chk("rnd gameOn", 12'(bus.gameOn), 12'(m_phase == 2 || m_phase == 3));
         chk("rnd ded", 12'(bus.ded), 12'(m_phase == 3 || m_phase == 4));
         chk("rnd bird_rst", 12'(bus.bird_rst), 12'(m_phase == 1));
         chk("rnd score", bus.score_bcd, to_bcd(m_score));
         chk("rnd flash", 12'(bus.flash), 12'((m_phase == 3) ? ((m_k / FLASH_DIV) % 2) : 0));
`ifdef FLAP_HISCORE_EN
         chk("rnd hiscore", bus.hiscore_bcd, to_bcd(m_hi));
`endif
         if (n % 500 == 0)
            $display("rnd %0d: state=%0d score=%h", n, bus.game_state, bus.score_bcd);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
